multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports CLK and reset_n.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  async active-low reset.
REQ-004 opcode  in  3  IR[2:0]; sampled only in DECODE.
REQ-005 mem_ready  in  1  memory handshake; high = current access completes this cycle.
REQ-006 run  in  1  high = leave IDLE and begin fetch.
REQ-007 Outputs, all 1 bit unless stated: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], halted, state[3:0].

Function
REQ-008 SHALL be a Moore FSM; every output is a function of state only, except that ir_write, pc_write and mem_write are additionally gated by mem_ready.
REQ-009 State encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ALU_WB=5, MEM_ADDR=6, MEM_RD=7, MEM_WB=8, MEM_WR=9, BRANCH=10, JUMP=11, LUI_WB=12, HALT=13.
REQ-010 IDLE -> FETCH when run=1; otherwise stay in IDLE.
REQ-011 FETCH SHALL assert mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-012 In FETCH, ir_write and pc_write SHALL assert only while mem_ready=1; FETCH -> DECODE on mem_ready=1, otherwise stay in FETCH.
REQ-013 DECODE SHALL assert alu_src_a=0, alu_src_b=11, alu_op=00 to compute the branch target.
REQ-014 DECODE dispatch by opcode SHALL be: 000->EXEC_R, 001->EXEC_I, 010/011->MEM_ADDR, 100->BRANCH, 101->JUMP, 110->LUI_WB, 111->HALT.
REQ-015 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; then -> ALU_WB.
REQ-016 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=10; then -> ALU_WB.
REQ-017 ALU_WB: reg_write=1, mem_to_reg=0; then -> FETCH.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; -> MEM_RD if the latched opcode is 010, -> MEM_WR if it is 011.
REQ-019 MEM_RD: mem_read=1, iord=1; -> MEM_WB on mem_ready=1, else hold.
REQ-020 MEM_WB: reg_write=1, mem_to_reg=1; then -> FETCH.
REQ-021 MEM_WR: iord=1, mem_write=mem_ready; -> FETCH on mem_ready=1, else hold.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then -> FETCH.
REQ-023 JUMP: pc_write=1, pc_source=10, reg_write=1, mem_to_reg=0 (link); then -> FETCH.
REQ-024 LUI_WB: alu_src_b=10, alu_op=11, reg_write=1, mem_to_reg=0; then -> FETCH.
REQ-025 HALT SHALL be terminal: halted=1, all write/strobe outputs 0, no exit except reset.
REQ-026 Any output not listed for a state SHALL be 0.
REQ-027 Opcode SHALL be latched into an internal register in DECODE; later states use the latched value.
REQ-028 run is ignored outside IDLE; deasserting run mid-instruction SHALL NOT abort it.
REQ-029 Cycle counts with mem_ready tied to 1: R/I=4, LW=5, SW=4, BEQ/JAL/LUI=3.
REQ-030 Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR SHALL add exactly one cycle, with no write strobe asserted during the wait.

Reset
REQ-031 reset_n=0 SHALL force state=IDLE, clear the latched opcode and drive all outputs to 0 immediately, without waiting for a clock edge.
REQ-032 Reset asserted mid-instruction SHALL abandon the instruction; after release the FSM SHALL stay in IDLE until run=1.

Verification
REQ-033 reset_n=0 during MEM_WR -> state=0, mem_write=0 the same cycle; release with run=0 -> state stays 0.
REQ-034 run=1, mem_ready=1, opcode=000 -> state sequence 1,2,3,5,1; reg_write=1 only in state 5, with mem_to_reg=0.
REQ-035 opcode=010, mem_ready low for 2 cycles in MEM_RD -> sequence 1,2,6,7,7,7,8,1; mem_to_reg=1 in state 8.
REQ-036 opcode=011, mem_ready=0 -> hold in state 9 with mem_write=0; raise mem_ready -> mem_write=1 for one cycle, then state 1.
REQ-037 opcode=100 -> sequence 1,2,10,1; pc_write_cond=1 and pc_source=01 in state 10; opcode=101 -> state 11 with pc_write=1, pc_source=10 and reg_write=1.
REQ-038 opcode=111 -> state 13 with halted=1, held for 10+ cycles regardless of run; reset -> state 0.

Source files
------------

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control
// Purpose  : Moore control FSM for a multi-cycle CPU datapath with memory
//            handshake stalls.
// Revision : 1.0
// ============================================================================
module multi_cycle_control (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic       mem_ready,
    input  logic       run,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_LUI_WB   = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_opcode;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_opcode <= 3'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
        end
    end

    assign state = r_state;

    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        halted        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Dispatch on the live opcode; it is latched at the same edge.
                alu_src_b = 2'b11;
                case (opcode)
                    3'b000:  w_next = S_EXEC_R;
                    3'b001:  w_next = S_EXEC_I;
                    3'b010,
                    3'b011:  w_next = S_MEM_ADDR;
                    3'b100:  w_next = S_BRANCH;
                    3'b101:  w_next = S_JUMP;
                    3'b110:  w_next = S_LUI_WB;
                    default: w_next = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                w_next    = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (r_opcode == 3'b010)      w_next = S_MEM_RD;
                else if (r_opcode == 3'b011) w_next = S_MEM_WR;
                else                         w_next = S_FETCH;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = mem_ready;
                if (mem_ready) w_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_LUI_WB: begin
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_control
// Purpose  : Scoreboard bench for multi_cycle_control with random stalls.
// Revision : 1.0
// ============================================================================
module tb_multi_cycle_control;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic [2:0] opcode;
    logic       mem_ready;
    logic       run;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_write, mem_to_reg, alu_src_a, halted;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;
    logic [19:0] exp_q[$];
    logic [19:0] dut_vec;

    multi_cycle_control dut (
        .CLK(CLK), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready), .run(run),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .halted(halted), .state(state)
    );

    always #5 CLK = ~CLK;

    assign dut_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                      pc_source, halted, state};

    // Reference control word for a named step of the instruction flow.
    function automatic logic [19:0] ctrl(input int st, input bit mr);
        bit pw = 0, pwc = 0, io = 0, mrd = 0, mw = 0, irw = 0, rw = 0, m2r = 0, sa = 0, h = 0;
        bit [1:0] sb = 0, op = 0, ps = 0;
        bit [3:0] s4;
        case (st)
            1:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            2:  sb = 2'b11;
            3:  begin sa = 1; op = 2'b10; end
            4:  begin sa = 1; sb = 2'b10; op = 2'b10; end
            5:  rw = 1;
            6:  begin sa = 1; sb = 2'b10; end
            7:  begin mrd = 1; io = 1; end
            8:  begin rw = 1; m2r = 1; end
            9:  begin io = 1; mw = mr; end
            10: begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            11: begin pw = 1; ps = 2'b10; rw = 1; end
            12: begin sb = 2'b10; op = 2'b11; rw = 1; end
            13: h = 1;
            default: ;
        endcase
        s4 = st[3:0];
        return {pw, pwc, io, mrd, mw, irw, rw, m2r, sa, sb, op, ps, h, s4};
    endfunction

    // One clock of stimulus; the expected control word for it goes to the scoreboard.
    task automatic cyc(input int st, input bit mr, input logic [2:0] op, input bit rn);
        @(posedge CLK);
        #1;
        mem_ready = mr;
        opcode    = op;
        run       = rn;
        exp_q.push_back(ctrl(st, mr));
    endtask

    function automatic logic [2:0] rop();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fetch_decode(input int op, input int fw);
        for (int i = 0; i < fw; i++) cyc(1, 0, rop(), rbit());
        cyc(1, 1, rop(), rbit());
        cyc(2, rbit(), 3'(op), rbit());
    endtask

    // Full instruction from FETCH back to the next FETCH entry.
    task automatic instr(input int op, input int fw, input int mwt);
        fetch_decode(op, fw);
        case (op)
            0: begin cyc(3, rbit(), rop(), rbit()); cyc(5, rbit(), rop(), rbit()); end
            1: begin cyc(4, rbit(), rop(), rbit()); cyc(5, rbit(), rop(), rbit()); end
            2: begin
                cyc(6, rbit(), rop(), rbit());
                for (int i = 0; i < mwt; i++) cyc(7, 0, rop(), rbit());
                cyc(7, 1, rop(), rbit());
                cyc(8, rbit(), rop(), rbit());
            end
            3: begin
                cyc(6, rbit(), rop(), rbit());
                for (int i = 0; i < mwt; i++) cyc(9, 0, rop(), rbit());
                cyc(9, 1, rop(), rbit());
            end
            4: cyc(10, rbit(), rop(), rbit());
            5: cyc(11, rbit(), rop(), rbit());
            6: cyc(12, rbit(), rop(), rbit());
            default: ;
        endcase
    endtask

    task automatic check_now(input string name, input logic [19:0] exp);
        checks++;
        if (dut_vec !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h state=%0d", name, dut_vec, exp, state);
        end
    endtask

    task automatic restart_from_idle();
        repeat (3) cyc(0, rbit(), rop(), 0);
        cyc(0, rbit(), rop(), 1);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [19:0] e;
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
                failures++;
                $display("FAIL ctrl_word t=%0t got=%h exp=%h state=%0d exp_state=%0d",
                         $time, dut_vec, e, state, e[3:0]);
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        run       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 3'b111;
        #2;
        check_now("reset_outputs", 20'h0);
        repeat (2) @(posedge CLK);
        #1;
        run     = 1'b0;
        reset_n = 1'b1;
        restart_from_idle();

        // Directed flows: R-type, LW with two stalls, SW with stalls, BEQ, JAL, LUI.
        instr(0, 0, 0);
        instr(2, 0, 2);
        instr(3, 0, 3);
        instr(4, 0, 0);
        instr(5, 0, 0);
        instr(6, 1, 0);

        for (int n = 0; n < 60; n++) begin
            instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)));
        end

        // Asynchronous reset while stalled in MEM_WR.
        fetch_decode(3, 0);
        cyc(6, rbit(), rop(), rbit());
        cyc(9, 0, rop(), 1);
        @(negedge CLK);
        #2;
        reset_n = 1'b0;
        #1;
        check_now("async_reset_in_mem_wr", 20'h0);
        @(posedge CLK);
        #1;
        check_now("held_in_reset", 20'h0);
        run     = 1'b0;
        reset_n = 1'b1;
        restart_from_idle();

        for (int n = 0; n < 20; n++) begin
            instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)));
        end

        // HALT is terminal regardless of run and mem_ready.
        fetch_decode(7, 0);
        repeat (12) cyc(13, rbit(), rop(), rbit());
        @(negedge CLK);
        #2;
        reset_n = 1'b0;
        #1;
        check_now("reset_from_halt", 20'h0);
        @(posedge CLK);
        #1;
        run     = 1'b0;
        reset_n = 1'b1;
        repeat (3) cyc(0, rbit(), rop(), 0);
        @(negedge CLK);
        #1;

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
